// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read
// port and holds the IF/ID pipeline register. Honours decode stalls, takes
// EX redirects with a one-slot flush, and stops fetching after a HLT is
// committed past decode.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bubble            stall request from decode (hold PC and IF/ID)
//   redirect          taken branch / JAL / JR resolved in EX
//   redirect_pc       redirect target PC
//   im_addr           instruction-memory address (the PC register)
//   im_re             instruction-memory read enable
//   im_rdata          instruction word, same-cycle read of im_addr
//   if_id_instr       IF/ID instruction
//   if_id_pc_plus1    IF/ID PC+1 (JAL link value)
//   if_id_valid       IF/ID holds a real instruction
//   halted            fetch has permanently stopped
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP      = 16'hB000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bubble,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] im_addr,
   output logic        im_re,
   input  logic [15:0] im_rdata,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc_plus1,
   output logic        if_id_valid,
   output logic        halted
);

   localparam int unsigned W = 16;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } state_t;

   state_t       state, state_n;
   logic [W-1:0] pc_n, instr_n, pc_plus1_n;
   logic         valid_n;
   logic [W-1:0] pc_inc;
   logic         is_hlt;

   assign pc_inc = im_addr + W'(1);
   assign is_hlt = (im_rdata[15:12] == 4'hF);

   // State, PC, IF/ID and the registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= RUN;
         im_addr        <= RESET_PC;
         if_id_instr    <= NOP;
         if_id_pc_plus1 <= '0;
         if_id_valid    <= 1'b0;
         im_re          <= 1'b1;
         halted         <= 1'b0;
      end else begin
         state          <= state_n;
         im_addr        <= pc_n;
         if_id_instr    <= instr_n;
         if_id_pc_plus1 <= pc_plus1_n;
         if_id_valid    <= valid_n;
         im_re          <= (state_n == RUN);
         halted         <= (state_n == HALTED);
      end
   end

   // Next-state and datapath selection
   always_comb begin
      state_n    = state;
      pc_n       = im_addr;
      instr_n    = if_id_instr;
      pc_plus1_n = if_id_pc_plus1;
      valid_n    = if_id_valid;
      case (state)
         RUN: begin
            // Redirect wins over a stall: the stalled ID instruction is younger
            if (redirect) begin
               pc_n       = redirect_pc;
               instr_n    = NOP;
               pc_plus1_n = '0;
               valid_n    = 1'b0;
            end else if (!bubble) begin
               instr_n    = im_rdata;
               pc_plus1_n = pc_inc;
               valid_n    = 1'b1;
               if (is_hlt) state_n = HALT_PEND;
               else        pc_n    = pc_inc;
            end
         end
         HALT_PEND: begin
            // A redirect here means the HLT was fetched on a wrong path
            if (redirect) begin
               pc_n       = redirect_pc;
               instr_n    = NOP;
               pc_plus1_n = '0;
               valid_n    = 1'b0;
               state_n    = RUN;
            end else if (!bubble) begin
               instr_n    = NOP;
               pc_plus1_n = '0;
               valid_n    = 1'b0;
               state_n    = HALTED;
            end
         end
         default: begin
            state_n = HALTED;
         end
      endcase
   end

endmodule
